// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RISC-V fetch stage.
//   NOP_INSTR     - canonical bubble instruction (addi x0,x0,0)
//   RESET_PC      - program counter value after reset
//   pcsrc_t       - next-PC select encodings driven from EX
//   fetch_state_t - instruction-fetch request FSM states
//   align_word()  - clears the low two bits of a target address
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'h0000_0004;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pcsrc_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10,
    DROP = 2'b11
  } fetch_state_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// if_id_register: pipeline register between fetch and decode.
//   clk, rst_n          - clock, asynchronous active-low reset (loads a bubble)
//   i_flush             - load a bubble (highest priority)
//   i_stall             - hold current contents
//   i_load              - load i_instr/i_pc/i_pc_plus4 as a valid instruction;
//                         when neither stalled nor loading, a bubble is loaded
//   o_instr, o_pc, o_pc_plus4, o_valid - register contents
module if_id_register
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Decode-side register: flush beats stall beats load; anything else is a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= 32'h0000_0000;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= 32'h0000_0000;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else if (i_stall) begin
      r_instr    <= r_instr;
      r_pc       <= r_pc;
      r_pc_plus4 <= r_pc_plus4;
      r_valid    <= r_valid;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end else begin
      r_instr    <= NOP_INSTR;
      r_pc       <= 32'h0000_0000;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch with a variable-latency memory port.
//   clk, rst_n             - clock, asynchronous active-low reset
//   StallF, StallD, FlushD - hazard-unit controls
//   PCSrcE                 - next-PC select (00 PC+4, 01 PCTargetE, 10 ALUResultE, 11 as 01)
//   PCTargetE, ALUResultE  - redirect targets from EX
//   imem_req, imem_addr    - memory request (valid / word address, stable until accepted)
//   imem_ready, imem_rdata - transfer completes when imem_req && imem_ready
//   InstrD, PCD, PCPlus4D, ValidD - IF/ID register contents
module fetch_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pcf;
  logic [31:0]  r_req_addr;
  logic [31:0]  r_buf;
  logic [31:0]  w_pcf_nxt;
  logic [31:0]  w_req_addr_nxt;
  logic [31:0]  w_buf_nxt;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_advance;
  logic         w_avail;
  logic [31:0]  w_word;
  logic [31:0]  w_pc_plus4;
  logic         w_if_load;

  assign w_redirect = (PCSrcE != 2'b00);
  assign w_advance  = !StallF && !StallD && !w_redirect;
  assign w_avail    = ((r_state == REQ) && imem_ready) || (r_state == HOLD);
  assign w_word     = (r_state == HOLD) ? r_buf : imem_rdata;
  assign w_pc_plus4 = r_pcf + PC_STEP;
  // Only a word fetched for the current, non-redirected PC may enter decode.
  assign w_if_load  = w_advance && w_avail;

  // Redirect target selection; the reserved 11 encoding aliases PC_TARGET.
  always_comb begin
    w_target = align_word(PCTargetE);
    case (PCSrcE)
      PC_ALU:  w_target = align_word(ALUResultE);
      default: w_target = align_word(PCTargetE);
    endcase
  end

  // Fetch FSM state, PC, request address and response buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pcf      <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_buf      <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pcf      <= w_pcf_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_buf      <= w_buf_nxt;
    end
  end

  // Next-state logic. Redirect wins over stalls. An outstanding request is
  // never withdrawn: on redirect without ready the FSM parks in DROP, keeping
  // imem_addr stable, and discards whatever that request returns.
  always_comb begin
    w_state_nxt    = r_state;
    w_pcf_nxt      = r_pcf;
    w_req_addr_nxt = r_req_addr;
    w_buf_nxt      = r_buf;
    case (r_state)
      IDLE: begin
        w_state_nxt    = REQ;
        w_req_addr_nxt = r_pcf;
      end
      REQ: begin
        if (w_redirect) begin
          w_pcf_nxt = w_target;
          if (imem_ready) begin
            w_state_nxt    = REQ;
            w_req_addr_nxt = w_target;
          end else begin
            w_state_nxt = DROP;
          end
        end else if (w_advance) begin
          if (imem_ready) begin
            w_pcf_nxt      = w_pc_plus4;
            w_req_addr_nxt = w_pc_plus4;
          end else begin
            w_state_nxt = REQ;
          end
        end else begin
          if (imem_ready) begin
            w_state_nxt = HOLD;
            w_buf_nxt   = imem_rdata;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_state_nxt    = REQ;
          w_pcf_nxt      = w_target;
          w_req_addr_nxt = w_target;
        end else if (w_advance) begin
          w_state_nxt    = REQ;
          w_pcf_nxt      = w_pc_plus4;
          w_req_addr_nxt = w_pc_plus4;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      DROP: begin
        if (w_redirect) begin
          w_pcf_nxt = w_target;
          if (imem_ready) begin
            w_state_nxt    = REQ;
            w_req_addr_nxt = w_target;
          end else begin
            w_state_nxt = DROP;
          end
        end else begin
          // PCF already holds the redirect target captured on DROP entry.
          if (imem_ready) begin
            w_state_nxt    = REQ;
            w_req_addr_nxt = r_pcf;
          end else begin
            w_state_nxt = DROP;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign imem_req  = (r_state == REQ) || (r_state == DROP);
  assign imem_addr = r_req_addr;

  if_id_register u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (FlushD),
    .i_stall    (StallD),
    .i_load     (w_if_load),
    .i_instr    (w_word),
    .i_pc       (r_pcf),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (InstrD),
    .o_pc       (PCD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (ValidD)
  );

endmodule
